fpu_normalize_round: RTL

- Post-add stage that sits directly downstream of the FPU adder/subtractor core.
- Consumes the core's raw result: sign, widened biased exponent, and an unnormalised mantissa with carry, guard and sticky bits.
- Normalises it with a one-bit-per-cycle shifter, rounds round-to-nearest-even, and emits the packed 32-bit word {sign, exp[5:0], mant[24:0]} plus a one-hot status.
- Valid/ready handshakes on both sides let it stall the adder or be stalled by the consumer.

---
 rtl/fpu_normalize_round.sv | 168 ++++++++++++++++
 1 files changed

// File: rtl/fpu_normalize_round.sv
// fpu_normalize_round
//   Post-add stage for the FPU adder/subtractor. Takes the adder's raw result
//   (sign, widened biased exponent, unnormalised mantissa with carry, guard
//   and sticky bits) and normalises it with a one-bit-per-cycle shifter. It
//   then rounds to nearest-even and emits a packed word with a one-hot status.
//
// Ports
//   clock100KHz : system clock, all state changes on the rising edge
//   reset       : synchronous, active-high; returns to IDLE, drops any operand
//   in_valid    : raw result available from the adder
//   in_ready    : high only while IDLE (stage can accept a new operand)
//   in_sign     : result sign
//   in_exp      : biased exponent with one bit of headroom
//   in_mant     : [28] carry, [27] hidden, [26:2] fraction, [1] guard, [0] sticky
//   out_valid   : data_out/status_out hold a finished result
//   out_ready   : consumer accepts the result
//   data_out    : {sign, exp[EXP_W-1:0], mant[MANT_W-1:0]}
//   status_out  : one-hot {UNDERFLOW, OVERFLOW, INEXACT, EXACT}

module fpu_normalize_round #(
  parameter int EXP_W  = 6,
  parameter int MANT_W = 25
) (
  input  logic                    clock100KHz,
  input  logic                    reset,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic                    in_sign,
  input  logic [EXP_W:0]          in_exp,
  input  logic [MANT_W+3:0]       in_mant,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [EXP_W+MANT_W:0]   data_out,
  output logic [3:0]              status_out
);

  // Exponent is carried two bits wider than the packed field so that a
  // carry increment plus a rounding increment can never wrap.
  localparam int XW = EXP_W + 2;

  localparam logic [XW-1:0] EXP_ONE = XW'(1);
  localparam logic [XW-1:0] EXP_MAX = XW'((2 ** EXP_W) - 2);

  localparam logic [3:0] ST_EXACT     = 4'b0001;
  localparam logic [3:0] ST_INEXACT   = 4'b0010;
  localparam logic [3:0] ST_OVERFLOW  = 4'b0100;
  localparam logic [3:0] ST_UNDERFLOW = 4'b1000;

  localparam int CARRY_BIT  = MANT_W + 3;
  localparam int HIDDEN_BIT = MANT_W + 2;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    ROUND,
    OUTPUT
  } state_t;

  state_t              state;
  logic                sign_q;
  logic [XW-1:0]       exp_q;
  logic [MANT_W+3:0]   mant_q;

  logic                guard_bit;
  logic                sticky_bit;
  logic                round_up;
  logic [MANT_W:0]     frac_sum;
  logic [MANT_W-1:0]   frac_rounded;
  logic [XW-1:0]       exp_rounded;

  // Round-to-nearest-even on the held mantissa. A fraction carry-out leaves
  // the low bits at zero, which is exactly the required "fraction=0, exp+1".
  always_comb begin
    guard_bit    = mant_q[1];
    sticky_bit   = mant_q[0];
    round_up     = guard_bit & (sticky_bit | mant_q[2]);
    frac_sum     = {1'b0, mant_q[MANT_W+1:2]} + {{MANT_W{1'b0}}, round_up};
    frac_rounded = frac_sum[MANT_W-1:0];
    exp_rounded  = exp_q + XW'(frac_sum[MANT_W]);
  end

  // Control FSM with registered handshake outputs. The result word is
  // written once when leaving SHIFT/ROUND and then only held in OUTPUT, so
  // it stays stable for the whole time the consumer stalls.
  always_ff @(posedge clock100KHz) begin
    if (reset) begin
      state      <= IDLE;
      in_ready   <= 1'b1;
      out_valid  <= 1'b0;
      data_out   <= '0;
      status_out <= 4'b0000;
      sign_q     <= 1'b0;
      exp_q      <= '0;
      mant_q     <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            sign_q   <= in_sign;
            exp_q    <= {1'b0, in_exp};
            mant_q   <= in_mant;
            in_ready <= 1'b0;
            state    <= SHIFT;
          end
        end

        SHIFT: begin
          if (mant_q == '0) begin
            data_out   <= {sign_q, {EXP_W{1'b0}}, {MANT_W{1'b0}}};
            status_out <= ST_EXACT;
            out_valid  <= 1'b1;
            state      <= OUTPUT;
          end else if (exp_q == '0) begin
            // A zero exponent from the adder is already below the normal range.
            data_out   <= {sign_q, {EXP_W{1'b0}}, {MANT_W{1'b0}}};
            status_out <= ST_UNDERFLOW;
            out_valid  <= 1'b1;
            state      <= OUTPUT;
          end else if (mant_q[CARRY_BIT]) begin
            // Bit 1 becomes the new sticky, so fold the old sticky into it.
            mant_q <= {1'b0, mant_q[MANT_W+3:2], mant_q[1] | mant_q[0]};
            exp_q  <= exp_q + EXP_ONE;
            state  <= ROUND;
          end else if (mant_q[HIDDEN_BIT]) begin
            state <= ROUND;
          end else if (exp_q <= EXP_ONE) begin
            data_out   <= {sign_q, {EXP_W{1'b0}}, {MANT_W{1'b0}}};
            status_out <= ST_UNDERFLOW;
            out_valid  <= 1'b1;
            state      <= OUTPUT;
          end else begin
            mant_q <= {mant_q[MANT_W+2:0], 1'b0};
            exp_q  <= exp_q - EXP_ONE;
          end
        end

        ROUND: begin
          if (exp_rounded > EXP_MAX) begin
            data_out   <= {sign_q, {EXP_W{1'b1}}, {MANT_W{1'b0}}};
            status_out <= ST_OVERFLOW;
          end else begin
            data_out   <= {sign_q, exp_rounded[EXP_W-1:0], frac_rounded};
            status_out <= (guard_bit | sticky_bit) ? ST_INEXACT : ST_EXACT;
          end
          out_valid <= 1'b1;
          state     <= OUTPUT;
        end

        OUTPUT: begin
          // Returning to IDLE here (rather than accepting) keeps a fresh
          // operand from being taken on the same edge as the output handshake.
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= IDLE;
          end
        end

        default: begin
          state     <= IDLE;
          in_ready  <= 1'b1;
          out_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule
